traffic_conflict_monitor: RTL and testbench

TRAFFIC_CONFLICT_MONITOR -- requirements
Module: traffic_conflict_monitor

---
 rtl/tlc_pkg.sv | 55 +++++
 rtl/tlc_lamp_tracker.sv | 62 ++++++
 rtl/traffic_conflict_monitor.sv | 152 +++++++++++++++
 tb/tb_traffic_conflict_monitor.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// Shared traffic-light types: lamp bundle, phase encoding,
// fault codes and controller timing shared with the light controller.
package tlc_pkg;

  localparam int GREEN_TIME  = 30;
  localparam int YELLOW_TIME = 5;

  typedef enum logic [1:0] {
    PH_RED    = 2'd0,
    PH_YELLOW = 2'd1,
    PH_GREEN  = 2'd2,
    PH_NONE   = 2'd3
  } phase_e;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } mon_state_e;

  localparam logic [2:0] FC_NONE    = 3'd0;
  localparam logic [2:0] FC_LAMP    = 3'd1;
  localparam logic [2:0] FC_CONFL   = 3'd2;
  localparam logic [2:0] FC_SEQ     = 3'd3;
  localparam logic [2:0] FC_SHORT_Y = 3'd4;
  localparam logic [2:0] FC_SHORT_G = 3'd5;
  localparam logic [2:0] FC_STUCK   = 3'd6;

  typedef struct packed {
    logic red;
    logic yellow;
    logic green;
  } lamps_t;

  typedef struct packed {
    logic lamp;
    logic seq;
    logic short_y;
    logic short_g;
    logic stuck;
  } trk_flags_t;

  // Exactly one lit lamp names the phase; anything else is PH_NONE.
  function automatic phase_e decode_phase(lamps_t l);
    phase_e p;
    case ({l.red, l.yellow, l.green})
      3'b100:  p = PH_RED;
      3'b010:  p = PH_YELLOW;
      3'b001:  p = PH_GREEN;
      default: p = PH_NONE;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/tlc_lamp_tracker.sv
// One direction: phase decode, previous phase, dwell counter.
// Ports: clk, rst, arm (INIT clear), first (establish cycle), lamps in; flags, red out.
module tlc_lamp_tracker
  import tlc_pkg::*;
#(
  parameter int MIN_GREEN  = GREEN_TIME,
  parameter int MIN_YELLOW = YELLOW_TIME,
  parameter int MAX_DWELL  = 48
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arm,
  input  logic       first,
  input  lamps_t     lamps,
  output trk_flags_t flags,
  output logic       red
);

  localparam logic [7:0] MIN_G = 8'(MIN_GREEN);
  localparam logic [7:0] MIN_Y = 8'(MIN_YELLOW);
  localparam logic [7:0] MAX_D = 8'(MAX_DWELL);

  phase_e     cur;
  phase_e     prev;
  logic [7:0] dwell;
  logic       changed;
  logic       legal;

  assign cur     = decode_phase(lamps);
  assign red     = (cur == PH_RED);
  assign changed = (cur != PH_NONE) && (cur != prev);

  assign legal =
    (prev == PH_GREEN  && cur == PH_YELLOW) ||
    (prev == PH_YELLOW && cur == PH_RED)    ||
    (prev == PH_RED    && cur == PH_GREEN);

  // Dwell holds the cycles already spent in prev when a change is seen.
  always_comb begin
    flags         = '0;
    flags.lamp    = (cur == PH_NONE);
    flags.seq     = changed && !legal;
    flags.short_y = changed && legal && cur == PH_RED
                    && dwell < MIN_Y;
    flags.short_g = changed && legal && cur == PH_YELLOW
                    && dwell < MIN_G;
    flags.stuck   = (dwell >= MAX_D);
  end

  always_ff @(posedge clk) begin
    if (rst || arm) begin
      prev  <= PH_RED;
      dwell <= 8'd0;
    end else if (first || changed) begin
      prev  <= cur;
      dwell <= 8'd1;
    end else if (dwell != 8'hff) begin
      dwell <= dwell + 8'd1;
    end
  end

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Safety monitor for a two-way signal: lamp, conflict, sequence, timing.
// Ports: clk, rst, six lamp inputs, fault_clr; fault, fault_code, fault_dir, flash_mode.
module traffic_conflict_monitor
  import tlc_pkg::*;
#(
  parameter int MIN_GREEN  = GREEN_TIME,
  parameter int MIN_YELLOW = YELLOW_TIME,
  parameter int MAX_DWELL  = 48
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ns_red,
  input  logic       ns_yellow,
  input  logic       ns_green,
  input  logic       ew_red,
  input  logic       ew_yellow,
  input  logic       ew_green,
  input  logic       fault_clr,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       fault_dir,
  output logic       flash_mode
);

  mon_state_e state;
  logic       first;
  lamps_t     s_ns;
  lamps_t     s_ew;
  trk_flags_t ns_f;
  trk_flags_t ew_f;
  logic       ns_is_red;
  logic       ew_is_red;
  logic       run;
  logic       seq_on;
  logic [2:0] det_code;
  logic       det_dir;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_ns <= '0;
      s_ew <= '0;
    end else begin
      s_ns <= '{ns_red, ns_yellow, ns_green};
      s_ew <= '{ew_red, ew_yellow, ew_green};
    end
  end

  tlc_lamp_tracker #(
    .MIN_GREEN (MIN_GREEN),
    .MIN_YELLOW(MIN_YELLOW),
    .MAX_DWELL (MAX_DWELL)
  ) u_ns (
    .clk  (clk),
    .rst  (rst),
    .arm  (state == ST_INIT),
    .first(run && first),
    .lamps(s_ns),
    .flags(ns_f),
    .red  (ns_is_red)
  );

  tlc_lamp_tracker #(
    .MIN_GREEN (MIN_GREEN),
    .MIN_YELLOW(MIN_YELLOW),
    .MAX_DWELL (MAX_DWELL)
  ) u_ew (
    .clk  (clk),
    .rst  (rst),
    .arm  (state == ST_INIT),
    .first(run && first),
    .lamps(s_ew),
    .flags(ew_f),
    .red  (ew_is_red)
  );

  assign run    = (state == ST_RUN);
  assign seq_on = run && !first;

  // Lowest code wins; NS beats EW on a tie.
  always_comb begin
    det_code = FC_NONE;
    det_dir  = 1'b0;
    if (run && ns_f.lamp) begin
      det_code = FC_LAMP;
    end else if (run && ew_f.lamp) begin
      det_code = FC_LAMP;
      det_dir  = 1'b1;
    end else if (run && !ns_is_red && !ew_is_red) begin
      det_code = FC_CONFL;
    end else if (seq_on && ns_f.seq) begin
      det_code = FC_SEQ;
    end else if (seq_on && ew_f.seq) begin
      det_code = FC_SEQ;
      det_dir  = 1'b1;
    end else if (seq_on && ns_f.short_y) begin
      det_code = FC_SHORT_Y;
    end else if (seq_on && ew_f.short_y) begin
      det_code = FC_SHORT_Y;
      det_dir  = 1'b1;
    end else if (seq_on && ns_f.short_g) begin
      det_code = FC_SHORT_G;
    end else if (seq_on && ew_f.short_g) begin
      det_code = FC_SHORT_G;
      det_dir  = 1'b1;
    end else if (seq_on && ns_f.stuck) begin
      det_code = FC_STUCK;
    end else if (seq_on && ew_f.stuck) begin
      det_code = FC_STUCK;
      det_dir  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_INIT;
      first      <= 1'b0;
      fault      <= 1'b0;
      fault_code <= FC_NONE;
      fault_dir  <= 1'b0;
    end else begin
      unique case (state)
        ST_INIT: begin
          state <= ST_RUN;
          first <= 1'b1;
        end
        ST_RUN: begin
          first <= 1'b0;
          if (det_code != FC_NONE) begin
            state      <= ST_FAULT;
            fault      <= 1'b1;
            fault_code <= det_code;
            fault_dir  <= det_dir;
          end
        end
        ST_FAULT: begin
          if (fault_clr) begin
            state      <= ST_INIT;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
            fault_dir  <= 1'b0;
          end
        end
        default: begin
          state <= ST_INIT;
        end
      endcase
    end
  end

  assign flash_mode = fault;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Directed bench for traffic_conflict_monitor.
// Drives/samples on negedge; a 70-cycle light controller model supplies legal traffic.
module tb_traffic_conflict_monitor;

  logic       clk;
  logic       rst;
  logic       ns_red, ns_yellow, ns_green;
  logic       ew_red, ew_yellow, ew_green;
  logic       fault_clr;
  logic       fault;
  logic [2:0] fault_code;
  logic       fault_dir;
  logic       flash_mode;

  int total = 0;
  int bad   = 0;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  traffic_conflict_monitor dut (
    .clk       (clk),
    .rst       (rst),
    .ns_red    (ns_red),
    .ns_yellow (ns_yellow),
    .ns_green  (ns_green),
    .ew_red    (ew_red),
    .ew_yellow (ew_yellow),
    .ew_green  (ew_green),
    .fault_clr (fault_clr),
    .fault     (fault),
    .fault_code(fault_code),
    .fault_dir (fault_dir),
    .flash_mode(flash_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic set_lamps(input logic [2:0] ns, input logic [2:0] ew);
    {ns_red, ns_yellow, ns_green} = ns;
    {ew_red, ew_yellow, ew_green} = ew;
  endtask

  // Legal controller: NS G30 Y5, then EW G30 Y5.
  task automatic drive_ctrl(input int t);
    int p;
    p = t % 70;
    if (p < 30)      set_lamps(G, R);
    else if (p < 35) set_lamps(Y, R);
    else if (p < 65) set_lamps(R, G);
    else             set_lamps(R, Y);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    fault_clr = 1'b0;
    drive_ctrl(0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    fault_clr = 1'b1;
    set_lamps(3'b111, 3'b011);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (fault !== 1'b0) begin
      bad++; $display("FAIL reset_fault: got %0b want 0", fault);
    end
    total++;
    if (fault_code !== 3'd0) begin
      bad++; $display("FAIL reset_code: got %0d want 0", fault_code);
    end
    total++;
    if (fault_dir !== 1'b0) begin
      bad++; $display("FAIL reset_dir: got %0b want 0", fault_dir);
    end
    total++;
    if (flash_mode !== 1'b0) begin
      bad++; $display("FAIL reset_flash: got %0b want 0", flash_mode);
    end
    fault_clr = 1'b0;
  endtask

  task automatic test_legal();
    do_reset();
    for (int t = 0; t < 1000; t++) begin
      drive_ctrl(t);
      @(negedge clk);
      total++;
      if (fault !== 1'b0) begin
        bad++;
        $display("FAIL legal_t%0d: fault=%0b code=%0d want 0",
                 t, fault, fault_code);
      end
    end
  endtask

  task automatic test_conflict();
    do_reset();
    for (int t = 0; t < 100; t++) begin
      drive_ctrl(t);
      @(negedge clk);
    end
    set_lamps(G, G);
    @(negedge clk);
    total++;
    if (fault !== 1'b0) begin
      bad++; $display("FAIL confl_early: got %0b want 0", fault);
    end
    drive_ctrl(101);
    @(negedge clk);
    total++;
    if (fault !== 1'b1) begin
      bad++; $display("FAIL confl_fault: got %0b want 1", fault);
    end
    total++;
    if (fault_code !== 3'd2) begin
      bad++; $display("FAIL confl_code: got %0d want 2", fault_code);
    end
    total++;
    if (fault_dir !== 1'b0) begin
      bad++; $display("FAIL confl_dir: got %0b want 0", fault_dir);
    end
    total++;
    if (flash_mode !== 1'b1) begin
      bad++; $display("FAIL confl_flash: got %0b want 1", flash_mode);
    end
    set_lamps(3'b111, 3'b000);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (fault_code !== 3'd2 || fault !== 1'b1) begin
        bad++;
        $display("FAIL confl_hold: code=%0d fault=%0b want 2/1",
                 fault_code, fault);
      end
    end
  endtask

  task automatic test_short_yellow();
    do_reset();
    for (int t = 0; t < 30; t++) begin
      drive_ctrl(t);
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      set_lamps(Y, R);
      @(negedge clk);
    end
    set_lamps(R, R);
    @(negedge clk);
    total++;
    if (fault !== 1'b0) begin
      bad++; $display("FAIL shorty_early: got %0b want 0", fault);
    end
    @(negedge clk);
    total++;
    if (fault_code !== 3'd4) begin
      bad++; $display("FAIL shorty_code: got %0d want 4", fault_code);
    end
    total++;
    if (fault_dir !== 1'b0) begin
      bad++; $display("FAIL shorty_dir: got %0b want 0", fault_dir);
    end
  endtask

  task automatic test_short_green();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_lamps(G, R);
      @(negedge clk);
    end
    set_lamps(Y, R);
    @(negedge clk);
    total++;
    if (fault !== 1'b0) begin
      bad++; $display("FAIL shortg_early: got %0b want 0", fault);
    end
    @(negedge clk);
    total++;
    if (fault_code !== 3'd5 || fault_dir !== 1'b0) begin
      bad++;
      $display("FAIL shortg_code: got %0d/%0b want 5/0",
               fault_code, fault_dir);
    end
  endtask

  // Fault registers at the edge after the sample where dwell hits 48.
  task automatic test_stuck();
    logic [2:0] exp_code;
    logic       exp_fault;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      set_lamps(G, R);
      @(negedge clk);
      exp_fault = (i >= 49);
      exp_code  = exp_fault ? 3'd6 : 3'd0;
      total++;
      if (fault !== exp_fault || fault_code !== exp_code ||
          fault_dir !== 1'b0) begin
        bad++;
        $display("FAIL stuck_i%0d: got %0b/%0d/%0b want %0b/%0d/0",
                 i, fault, fault_code, fault_dir, exp_fault, exp_code);
      end
    end
  endtask

  task automatic test_lamp_clear();
    do_reset();
    for (int t = 0; t < 10; t++) begin
      drive_ctrl(t);
      @(negedge clk);
    end
    set_lamps(G, 3'b011);
    @(negedge clk);
    fault_clr = 1'b1;
    total++;
    if (fault !== 1'b0) begin
      bad++; $display("FAIL lamp_early: got %0b want 0", fault);
    end
    @(negedge clk);
    total++;
    if (fault !== 1'b1 || fault_code !== 3'd1 || fault_dir !== 1'b1) begin
      bad++;
      $display("FAIL lamp_code: got %0b/%0d/%0b want 1/1/1",
               fault, fault_code, fault_dir);
    end
    @(negedge clk);
    fault_clr = 1'b0;
    total++;
    if (fault !== 1'b0 || fault_code !== 3'd0) begin
      bad++;
      $display("FAIL clr_wins: got %0b/%0d want 0/0", fault, fault_code);
    end
    @(negedge clk);
    total++;
    if (fault !== 1'b0) begin
      bad++; $display("FAIL rearm_first: got %0b want 0", fault);
    end
    @(negedge clk);
    total++;
    if (fault !== 1'b1 || fault_code !== 3'd1 || fault_dir !== 1'b1) begin
      bad++;
      $display("FAIL redetect: got %0b/%0d/%0b want 1/1/1",
               fault, fault_code, fault_dir);
    end
    drive_ctrl(0);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    total++;
    if (fault !== 1'b0 || fault_code !== 3'd0 || fault_dir !== 1'b0 ||
        flash_mode !== 1'b0) begin
      bad++;
      $display("FAIL clr_out: got %0b/%0d/%0b/%0b want 0/0/0/0",
               fault, fault_code, fault_dir, flash_mode);
    end
    for (int t = 0; t < 200; t++) begin
      drive_ctrl(t);
      @(negedge clk);
      total++;
      if (fault !== 1'b0) begin
        bad++;
        $display("FAIL rearm_t%0d: fault=%0b code=%0d want 0",
                 t, fault, fault_code);
      end
    end
  endtask

  task automatic test_seq_reset();
    do_reset();
    for (int t = 0; t < 30; t++) begin
      drive_ctrl(t);
      @(negedge clk);
    end
    set_lamps(R, R);
    @(negedge clk);
    total++;
    if (fault !== 1'b0) begin
      bad++; $display("FAIL seq_early: got %0b want 0", fault);
    end
    @(negedge clk);
    total++;
    if (fault_code !== 3'd3 || fault_dir !== 1'b0) begin
      bad++;
      $display("FAIL seq_code: got %0d/%0b want 3/0", fault_code, fault_dir);
    end
    rst       = 1'b1;
    fault_clr = 1'b1;
    set_lamps(3'b111, 3'b111);
    @(negedge clk);
    total++;
    if (fault !== 1'b0 || fault_code !== 3'd0 || fault_dir !== 1'b0 ||
        flash_mode !== 1'b0) begin
      bad++;
      $display("FAIL rst_in_fault: got %0b/%0d/%0b/%0b want 0/0/0/0",
               fault, fault_code, fault_dir, flash_mode);
    end
    rst       = 1'b0;
    fault_clr = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    fault_clr = 1'b0;
    set_lamps(R, R);
    test_reset();
    test_legal();
    test_conflict();
    test_short_yellow();
    test_short_green();
    test_stuck();
    test_lamp_clear();
    test_seq_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
